button_event_gen: RTL
=====================

Name: button_event_gen

Overview:
- Downstream consumer of the FSM button debouncer.
- Takes the debounced active-low button level and turns it into single-cycle events for the control logic and display counters: press, release, long-press and auto-repeat.
- Keeps a wrapping 8-bit press counter.
- Shares the debouncer's clock domain, so no input synchronizer is needed.

Parameters:
- TICK_BITS, 10, width of the free-running prescaler; tick fires when the prescaler is all-ones (once per 2^TICK_BITS cycles).
- LONG_TICKS, 500, ticks of continuous hold before long_pulse; legal range 2..65535.
- REPEAT_TICKS, 100, ticks between repeat_pulse events while in long-hold; legal range 2..65535.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset.
- btn_n  in  1  debounced button level from the debouncer; 0 = pressed.
- held  out  1  registered level; 1 while the FSM is in PRESSED or LONG.
- press_pulse  out  1  one-cycle pulse on a press.
- release_pulse  out  1  one-cycle pulse on a release.
- long_pulse  out  1  one-cycle pulse when a hold reaches LONG_TICKS.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_TICKS while in long-hold.
- press_count  out  8  count of press_pulse plus repeat_pulse events; wraps 255->0.

Interface rules:
- One clock; reset is asynchronous and active-low.
- Clock port is named clock; reset port is named reset_n.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - prescaler=0, hold_cnt=0, rpt_cnt=0, prev=0, state=IDLE.
  - All outputs 0, press_count=0.
  - Assertion mid-hold aborts immediately; no release_pulse is emitted.
- Signal definitions:
  - pressed = ~btn_n, sampled at each edge.
  - prev = pressed from the previous cycle.
  - rise = pressed & ~prev; fall = ~pressed & prev.
- Prescaler: increments every cycle and wraps. tick = &prescaler, combinational.
- All pulse outputs are registered:
  - Asserted for exactly one cycle, starting at the first rising edge where btn_n is sampled low (press) or high (release).
  - Latency is one edge from sampling.
- States are IDLE, PRESSED and LONG. Encoding lives in the package; held = (state != IDLE).
- IDLE:
  - rise -> PRESSED; press_pulse=1; hold_cnt=0.
  - The tick phase is not re-aligned; the first hold tick may arrive early by up to 2^TICK_BITS-1 cycles. This is accepted.
- PRESSED:
  - fall -> IDLE; release_pulse=1. Release has priority over tick.
  - Otherwise, on tick: if hold_cnt == LONG_TICKS-1 -> LONG, long_pulse=1, rpt_cnt=0; else hold_cnt++.
- LONG:
  - fall -> IDLE; release_pulse=1. Release has priority over tick.
  - Otherwise, on tick: if rpt_cnt == REPEAT_TICKS-1 -> repeat_pulse=1, rpt_cnt=0; else rpt_cnt++.
  - The first repeat occurs REPEAT_TICKS ticks after long_pulse.
- press_count:
  - +1 in the cycle press_pulse or repeat_pulse is asserted.
  - These two can never coincide.
  - 8-bit modulo wrap, no saturation.
- Counter width: hold_cnt and rpt_cnt are 16 bits; compares are unsigned.
- Boundary cases:
  - Button held through reset deassertion: prev=0, so the first edge after reset produces press_pulse and enters PRESSED. This is intentional.
  - Invalid state encoding -> IDLE on the next edge, with no pulses.
  - rise and fall cannot occur in the same cycle.
  - A glitch shorter than one cycle is impossible, because the input comes from a registered FSM.

Decomposition:
- Package btn_pkg:
  - State encoding localparams: IDLE=2'd0, PRESSED=2'd1, LONG=2'd2.
  - Default constants: TICK_BITS, LONG_TICKS, REPEAT_TICKS.
  - Counter width (16).
- Sub-module tick_prescaler (parameter TICK_BITS; ports clock, reset_n, tick):
  - Isolates the free-running counter.
  - Reusable by the debouncer and other timers.
- Everything else lives in button_event_gen: FSM, counters, pulse registers.

Test Plan (TICK_BITS=2, LONG_TICKS=3, REPEAT_TICKS=2):
- Reset then idle: reset_n=0 for 3 cycles, btn_n=1 -> all outputs 0, press_count=0 throughout.
- Short press: btn_n low for 5 cycles, then high -> press_pulse for 1 cycle at the first edge; held=1 for 5 cycles; release_pulse for 1 cycle at the first high edge; long_pulse never; press_count=1.
- Long hold: btn_n low for 40 cycles -> long_pulse on the 3rd tick; repeat_pulse every 2nd tick thereafter (every 8 cycles); press_count = 1 + number of repeats. Check the exact cycles against the tick model.
- Release on a tick edge: release in the same cycle a tick would complete LONG_TICKS -> release_pulse=1, long_pulse=0, state IDLE.
- Reset mid-hold: assert reset_n=0 while in LONG -> outputs clear asynchronously, with no release_pulse. Deassert with btn_n still low -> press_pulse at the next edge, press_count=1.
- Counter wrap: 256 short presses -> press_count returns to 0; the 257th press gives 1.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and default constants for the button event generator
package btn_pkg;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_PRESSED = 2'd1;
    localparam logic [1:0] ENC_LONG    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ENC_IDLE,
        PRESSED = ENC_PRESSED,
        LONG    = ENC_LONG
    } btn_state_e;

    localparam int DEF_TICK_BITS    = 10;
    localparam int DEF_LONG_TICKS   = 500;
    localparam int DEF_REPEAT_TICKS = 100;
    localparam int CNT_W            = 16;
    localparam int PRESS_CNT_W      = 8;

endpackage

// File: rtl/button_event_gen_if.sv
// rtl/button_event_gen_if.sv - debounced button level in, event pulses and press count out
interface button_event_gen_if;
    import btn_pkg::*;

    logic                   btn_n;
    logic                   held;
    logic                   press_pulse;
    logic                   release_pulse;
    logic                   long_pulse;
    logic                   repeat_pulse;
    logic [PRESS_CNT_W-1:0] press_count;

    modport master (
        output btn_n,
        input  held, press_pulse, release_pulse, long_pulse, repeat_pulse, press_count
    );

    modport slave (
        input  btn_n,
        output held, press_pulse, release_pulse, long_pulse, repeat_pulse, press_count
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running prescaler, tick while the count is all-ones
module tick_prescaler
    import btn_pkg::*;
#(
    parameter int TICK_BITS = DEF_TICK_BITS
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    logic [TICK_BITS-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TICK_BITS'(1);
        end
    end

    assign tick = &r_count;

endmodule

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - turns the debounced button level into press/release/long/repeat pulses
module button_event_gen
    import btn_pkg::*;
#(
    parameter int TICK_BITS    = DEF_TICK_BITS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic               clock,
    input  logic               reset_n,
    button_event_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    btn_state_e             r_state;
    btn_state_e             w_next_state;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [CNT_W-1:0]       w_next_hold_cnt;
    logic [CNT_W-1:0]       r_rpt_cnt;
    logic [CNT_W-1:0]       w_next_rpt_cnt;
    logic                   r_prev;
    logic                   r_held;
    logic                   r_press_pulse;
    logic                   r_release_pulse;
    logic                   r_long_pulse;
    logic                   r_repeat_pulse;
    logic [PRESS_CNT_W-1:0] r_press_count;

    logic w_tick;
    logic w_pressed;
    logic w_rise;
    logic w_fall;
    logic w_press_nx;
    logic w_release_nx;
    logic w_long_nx;
    logic w_repeat_nx;

    tick_prescaler #(
        .TICK_BITS (TICK_BITS)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    assign w_pressed = ~bus.btn_n;
    assign w_rise    = w_pressed & ~r_prev;
    assign w_fall    = ~w_pressed & r_prev;

    // Release is checked before the tick so a release landing on a tick edge never fires long/repeat.
    always_comb begin
        w_next_state    = r_state;
        w_next_hold_cnt = r_hold_cnt;
        w_next_rpt_cnt  = r_rpt_cnt;
        w_press_nx      = 1'b0;
        w_release_nx    = 1'b0;
        w_long_nx       = 1'b0;
        w_repeat_nx     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_next_state    = PRESSED;
                    w_press_nx      = 1'b1;
                    w_next_hold_cnt = '0;
                end
            end
            PRESSED: begin
                if (w_fall) begin
                    w_next_state = IDLE;
                    w_release_nx = 1'b1;
                end else if (w_tick) begin
                    if (r_hold_cnt == LONG_LAST) begin
                        w_next_state   = LONG;
                        w_long_nx      = 1'b1;
                        w_next_rpt_cnt = '0;
                    end else begin
                        w_next_hold_cnt = r_hold_cnt + CNT_W'(1);
                    end
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_next_state = IDLE;
                    w_release_nx = 1'b1;
                end else if (w_tick) begin
                    if (r_rpt_cnt == REPEAT_LAST) begin
                        w_repeat_nx    = 1'b1;
                        w_next_rpt_cnt = '0;
                    end else begin
                        w_next_rpt_cnt = r_rpt_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_hold_cnt      <= '0;
            r_rpt_cnt       <= '0;
            r_prev          <= 1'b0;
            r_held          <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_state         <= w_next_state;
            r_hold_cnt      <= w_next_hold_cnt;
            r_rpt_cnt       <= w_next_rpt_cnt;
            r_prev          <= w_pressed;
            r_held          <= (w_next_state != IDLE);
            r_press_pulse   <= w_press_nx;
            r_release_pulse <= w_release_nx;
            r_long_pulse    <= w_long_nx;
            r_repeat_pulse  <= w_repeat_nx;
            r_press_count   <= r_press_count + PRESS_CNT_W'(w_press_nx | w_repeat_nx);
        end
    end

    assign bus.held          = r_held;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.long_pulse    = r_long_pulse;
    assign bus.repeat_pulse  = r_repeat_pulse;
    assign bus.press_count   = r_press_count;

endmodule
